// File: rtl/vc_weighted_arbiter.sv
// Weighted round-robin mover from two VC FIFOs into two destination FIFOs.
// Pop is combinational; routed push lands one cycle later. Stalls on any destination almost-full.
module vc_weighted_arbiter #(
    parameter int DATA_W   = 6,
    parameter int DEST_BIT = 5,
    parameter int WEIGHT   = 3,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic              d1_push,
    output logic [DATA_W-1:0] d_data,
    output logic [1:0]        arb_state,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    localparam int WC_W = (WEIGHT < 1) ? 1 : $clog2(WEIGHT + 1);
    localparam logic [WC_W-1:0] WMAX = WC_W'(WEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WC_W-1:0]   r_wcnt;
    logic              r_pend;
    logic              r_pend_src;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_go;
    logic              w_vc0_turn;
    logic              w_gnt0;
    logic              w_gnt1;

    assign w_go       = en & ~d0_almost_full & ~d1_almost_full;
    assign w_vc0_turn = (r_wcnt < WMAX);

    // Gated with reset so no FIFO is popped while the block is held in reset.
    assign w_gnt0 = reset & w_go & ~vc0_empty & (vc1_empty | w_vc0_turn);
    assign w_gnt1 = reset & w_go & ~vc1_empty & (vc0_empty | ~w_vc0_turn);

    assign vc0_pop = w_gnt0;
    assign vc1_pop = w_gnt1;

    assign d_data  = r_pend ? (r_pend_src ? vc1_data : vc0_data) : '0;
    assign d0_push = r_pend & ~d_data[DEST_BIT];
    assign d1_push = r_pend &  d_data[DEST_BIT];

    assign arb_state = r_state;
    assign gnt_cnt0  = r_cnt0;
    assign gnt_cnt1  = r_cnt1;

    always_comb begin
        w_state_nxt = ST_ARB;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else if (d0_almost_full || d1_almost_full) begin
            w_state_nxt = ST_STALL;
        end else if (vc0_empty && vc1_empty) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wcnt     <= '0;
            r_pend     <= 1'b0;
            r_pend_src <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_gnt0 | w_gnt1;
            r_pend_src <= w_gnt1;

            // VC0 streak only counts while VC1 is actually waiting.
            if (vc1_empty || w_gnt1) begin
                r_wcnt <= '0;
            end else if (w_gnt0) begin
                r_wcnt <= r_wcnt + 1'b1;
            end

            if (w_gnt0) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_gnt1) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vc_weighted_arbiter.sv
// Randomised scoreboard bench for vc_weighted_arbiter with a queue-based reference model.
module tb_vc_weighted_arbiter;

    localparam int DATA_W   = 6;
    localparam int DEST_BIT = 5;
    localparam int WEIGHT   = 3;
    localparam int CNT_W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              vc0_empty, vc1_empty;
    logic [DATA_W-1:0] vc0_data, vc1_data;
    logic              d0_almost_full, d1_almost_full;
    logic              vc0_pop, vc1_pop, d0_push, d1_push;
    logic [DATA_W-1:0] d_data;
    logic [1:0]        arb_state;
    logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;

    vc_weighted_arbiter #(
        .DATA_W(DATA_W), .DEST_BIT(DEST_BIT), .WEIGHT(WEIGHT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_push(d0_push), .d1_push(d1_push), .d_data(d_data),
        .arb_state(arb_state), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] w;
    } exp_t;

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    exp_t              exp_q[$];

    // Reference model state
    int                streak = 0;
    logic [CNT_W-1:0]  m_cnt0 = '0;
    logic [CNT_W-1:0]  m_cnt1 = '0;
    int                exp_state = 0;
    logic [DATA_W-1:0] pd0, pd1;
    bit                pv0 = 0, pv1 = 0;

    // Stimulus knobs
    int en_mode  = 1;   // 0 off, 1 on, 2 random
    bit af0_force = 0;
    int af_pct   = 0;
    int fill_pct = 0;
    int last_pop = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        return DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
    endfunction

    // Monitor: every destination push is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (d0_push || d1_push) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_push", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("push_cycle", cyc, e.due);
                    chk("d_data", d_data, e.w);
                    chk("d0_push", d0_push, !e.w[DEST_BIT]);
                    chk("d1_push", d1_push, e.w[DEST_BIT]);
                end
            end else begin
                chk("d_data_idle", d_data, 0);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    chk("missing_push", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock cycle: drive inputs, predict and check, then advance past the edge.
    task automatic step();
        int  g;
        bit  h0, h1, go;
        if (pv0) begin vc0_data = pd0; pv0 = 0; end
        if (pv1) begin vc1_data = pd1; pv1 = 0; end
        en = (en_mode == 2) ? ($urandom_range(0, 9) != 0) : (en_mode != 0);
        d0_almost_full = af0_force || ($urandom_range(0, 99) < af_pct);
        d1_almost_full = ($urandom_range(0, 99) < af_pct);
        if (fill_pct > 0) begin
            if (q0.size() < 8 && $urandom_range(0, 99) < fill_pct) q0.push_back(rand_word());
            if (q1.size() < 8 && $urandom_range(0, 99) < fill_pct) q1.push_back(rand_word());
        end
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        #1;
        chk("arb_state", arb_state, exp_state);
        chk("gnt_cnt0", gnt_cnt0, m_cnt0);
        chk("gnt_cnt1", gnt_cnt1, m_cnt1);

        h0 = (q0.size() > 0);
        h1 = (q1.size() > 0);
        go = en && !d0_almost_full && !d1_almost_full;
        g  = -1;
        if (go) begin
            if (h0 && h1)  g = (streak < WEIGHT) ? 0 : 1;
            else if (h0)   g = 0;
            else if (h1)   g = 1;
        end
        chk("vc0_pop", vc0_pop, (g == 0));
        chk("vc1_pop", vc1_pop, (g == 1));
        last_pop = vc1_pop ? 1 : (vc0_pop ? 0 : -1);

        if (!h1 || g == 1) streak = 0;
        else if (g == 0)   streak++;

        if (!en)                                   exp_state = 0;
        else if (d0_almost_full || d1_almost_full) exp_state = 2;
        else if (!h0 && !h1)                       exp_state = 0;
        else                                       exp_state = 1;

        if (g == 0) begin
            pd0 = q0.pop_front(); pv0 = 1; m_cnt0++;
            exp_q.push_back('{due: cyc + 1, w: pd0});
        end else if (g == 1) begin
            pd1 = q1.pop_front(); pv1 = 1; m_cnt1++;
            exp_q.push_back('{due: cyc + 1, w: pd1});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        en_mode = 1; af0_force = 0; af_pct = 0; fill_pct = 0;
        for (int i = 0; i < 600 && (q0.size() > 0 || q1.size() > 0); i++) step();
        step();
        step();
    endtask

    initial begin
        int pat[8];
        pat = '{0, 0, 0, 1, 0, 0, 0, 1};
        reset = 1'b0; en = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b1;
        vc0_data = '0; vc1_data = '0; d0_almost_full = 1'b0; d1_almost_full = 1'b0;

        // Reset values
        #12;
        chk("rst_arb_state", arb_state, 0);
        chk("rst_cnt0", gnt_cnt0, 0);
        chk("rst_cnt1", gnt_cnt1, 0);
        chk("rst_pushes", {30'd0, d0_push, d1_push}, 0);
        chk("rst_d_data", d_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        cyc++;
        #1;

        // Weighted pattern with both VCs full
        for (int i = 0; i < 8; i++) begin q0.push_back(rand_word()); q1.push_back(rand_word()); end
        for (int i = 0; i < 8; i++) begin
            step();
            chk("wrr_pattern", last_pop, pat[i]);
        end
        chk("wrr_cnt0_after8", gnt_cnt0, 6);
        chk("wrr_cnt1_after8", gnt_cnt1, 2);
        drain();

        // VC1-only routing to D1 then D0
        q1.push_back(6'b100001);
        q1.push_back(6'b000010);
        drain();

        // Almost-full stall and resume
        for (int i = 0; i < 10; i++) begin q0.push_back(rand_word()); q1.push_back(rand_word()); end
        repeat (3) step();
        af0_force = 1;
        repeat (3) step();
        af0_force = 0;
        repeat (2) step();

        // Disable with both non-empty, then re-enable
        en_mode = 0;
        repeat (3) step();
        en_mode = 1;
        repeat (2) step();
        drain();

        // 256 VC0-only grants wrap the counter
        for (int i = 0; i < 256; i++) q0.push_back(rand_word());
        drain();

        // Randomised traffic
        en_mode = 2; af_pct = 10; fill_pct = 40;
        repeat (800) step();
        drain();

        // Asynchronous reset with a word in flight
        q0.push_back(rand_word());
        q0.push_back(rand_word());
        step();
        vc0_data = pd0; pv0 = 0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_pushes", {30'd0, d0_push, d1_push}, 0);
        chk("mid_rst_pops", {30'd0, vc0_pop, vc1_pop}, 0);
        chk("mid_rst_d_data", d_data, 0);
        exp_q.delete();
        streak = 0; m_cnt0 = '0; m_cnt1 = '0; exp_state = 0;
        en = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        chk("mid_rst_state", arb_state, 0);
        chk("mid_rst_cnt0", gnt_cnt0, 0);
        chk("mid_rst_cnt1", gnt_cnt1, 0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        drain();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
